// File: rtl/sprite_palette_pkg.sv
// Shared types and power-up palette table for the sprite palette bank.
// Palettes are packed {R,G,B} words, COLOR_W bits per channel.
package sprite_palette_pkg;

  localparam int DEF_INDEX_W = 3;
  localparam int DEF_NUM_PAL = 4;
  localparam int DEF_COLOR_W = 4;
  localparam int DEF_ENTRIES = 2 ** DEF_INDEX_W;

  typedef struct packed {
    logic [DEF_COLOR_W-1:0] r;
    logic [DEF_COLOR_W-1:0] g;
    logic [DEF_COLOR_W-1:0] b;
  } rgb_t;

  localparam logic [3*DEF_COLOR_W-1:0]
    DEFAULT_PAL [DEF_NUM_PAL][DEF_ENTRIES] = '{
    '{12'hB21, 12'h0E0, 12'hDA9, 12'h000,
      12'h766, 12'h060, 12'hEEE, 12'h421},
    '{12'h000, 12'hF00, 12'h0F0, 12'h00F,
      12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF},
    '{12'h000, 12'h111, 12'h333, 12'h555,
      12'h777, 12'h999, 12'hBBB, 12'hDDD},
    '{12'h000, 12'h820, 12'hA40, 12'hC60,
      12'hE80, 12'hFA0, 12'hFC4, 12'hFE8}
  };

  // Entries beyond the table (larger bank parameters) power up black.
  function automatic rgb_t default_entry(input int pal, input int idx);
    rgb_t v;
    v = '0;
    if (pal < DEF_NUM_PAL && idx < DEF_ENTRIES)
      v = rgb_t'(DEFAULT_PAL[pal][idx]);
    return v;
  endfunction

endpackage

// File: rtl/sprite_palette_bank_flash.sv
// Hit-flash frame timer: frame countdown, on/off phase, latched palette.
// A trigger always wins over a coincident frame_start.
module sprite_flash_timer #(
  parameter int FLASH_FRAMES = 8,
  parameter int FLASH_PERIOD = 2,
  parameter int PAL_W        = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_frame_start,
  input  logic             i_trigger,
  input  logic [PAL_W-1:0] i_pal,
  output logic             o_flash_on,
  output logic [PAL_W-1:0] o_flash_pal_q,
  output logic             o_active
);

  localparam int CNT_W = $clog2(FLASH_FRAMES + 1);
  localparam int PH_W  = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(FLASH_PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [PH_W-1:0]  r_ph;
  logic             r_on;
  logic [PAL_W-1:0] r_pal;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_ph  <= '0;
      r_on  <= 1'b0;
      r_pal <= '0;
    end else if (i_trigger) begin
      r_cnt <= CNT_W'(FLASH_FRAMES);
      r_ph  <= '0;
      r_on  <= 1'b1;
      r_pal <= i_pal;
    end else if (i_frame_start && r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_ph == PH_LAST) begin
        r_ph <= '0;
        r_on <= ~r_on;
      end else begin
        r_ph <= r_ph + PH_W'(1);
      end
    end
  end

  assign o_active      = (r_cnt != '0);
  assign o_flash_on    = o_active && r_on;
  assign o_flash_pal_q = r_pal;

endmodule

// File: rtl/sprite_palette_bank.sv
// Shared runtime-writable sprite palette bank with registered lookup,
// transparency keying and hit-flash override.
module sprite_palette_bank
  import sprite_palette_pkg::*;
#(
  parameter int INDEX_W      = DEF_INDEX_W,
  parameter int NUM_PAL      = DEF_NUM_PAL,
  parameter int COLOR_W      = DEF_COLOR_W,
  parameter int TRANSP_INDEX = 0,
  parameter int FLASH_FRAMES = 8,
  parameter int FLASH_PERIOD = 2,
  localparam int PAL_W = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1,
  localparam int RGB_W = 3 * COLOR_W
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_frame_start,
  input  logic               i_pix_valid,
  input  logic [PAL_W-1:0]   i_pix_pal,
  input  logic [INDEX_W-1:0] i_pix_index,
  output logic               o_out_valid,
  output logic [COLOR_W-1:0] o_red,
  output logic [COLOR_W-1:0] o_green,
  output logic [COLOR_W-1:0] o_blue,
  output logic               o_transparent,
  input  logic               i_wr_en,
  input  logic [PAL_W-1:0]   i_wr_pal,
  input  logic [INDEX_W-1:0] i_wr_index,
  input  logic [RGB_W-1:0]   i_wr_rgb,
  input  logic               i_flash_trigger,
  input  logic [PAL_W-1:0]   i_flash_pal,
  output logic               o_flash_active
);

  localparam int ENTRIES = 2 ** INDEX_W;
  localparam logic [PAL_W:0]     NUM_PAL_L = (PAL_W+1)'(NUM_PAL);
  localparam logic [INDEX_W-1:0] TRANSP_L  = INDEX_W'(TRANSP_INDEX);

  logic [RGB_W-1:0] r_mem [NUM_PAL][ENTRIES];
  logic             r_valid;
  logic [RGB_W-1:0] r_rgb;
  logic             r_transp;

  logic             w_flash_on;
  logic [PAL_W-1:0] w_flash_pal;
  logic             w_pix_ok;
  logic             w_wr_ok;
  logic             w_transp;
  logic             w_flash_hit;
  logic [RGB_W-1:0] w_rgb;

  sprite_flash_timer #(
    .FLASH_FRAMES (FLASH_FRAMES),
    .FLASH_PERIOD (FLASH_PERIOD),
    .PAL_W        (PAL_W)
  ) u_flash (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_frame_start (i_frame_start),
    .i_trigger     (i_flash_trigger),
    .i_pal         (i_flash_pal),
    .o_flash_on    (w_flash_on),
    .o_flash_pal_q (w_flash_pal),
    .o_active      (o_flash_active)
  );

  assign w_pix_ok = ({1'b0, i_pix_pal} < NUM_PAL_L);
  assign w_wr_ok  = ({1'b0, i_wr_pal} < NUM_PAL_L);
  assign w_transp = (i_pix_index == TRANSP_L);
  assign w_flash_hit = w_flash_on && !w_transp
                       && (i_pix_pal == w_flash_pal);

  always_comb begin
    w_rgb = '0;
    if (w_pix_ok)
      w_rgb = w_flash_hit ? '1 : r_mem[i_pix_pal][i_pix_index];
  end

  // Storage read above sees pre-write contents: read-before-write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int p = 0; p < NUM_PAL; p++)
        for (int e = 0; e < ENTRIES; e++)
          r_mem[p][e] <= RGB_W'(default_entry(p, e));
    end else if (i_wr_en && w_wr_ok) begin
      r_mem[i_wr_pal][i_wr_index] <= i_wr_rgb;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid  <= 1'b0;
      r_rgb    <= '0;
      r_transp <= 1'b0;
    end else begin
      r_valid <= i_pix_valid;
      if (i_pix_valid) begin
        r_rgb    <= w_rgb;
        r_transp <= w_transp;
      end
    end
  end

  assign o_out_valid   = r_valid;
  assign o_transparent = r_transp;
  assign o_red   = r_rgb[RGB_W-1 -: COLOR_W];
  assign o_green = r_rgb[2*COLOR_W-1 -: COLOR_W];
  assign o_blue  = r_rgb[COLOR_W-1:0];

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed bench for sprite_palette_bank: frame-count flash model plus
// hand-computed literal checks.
module tb_sprite_palette_bank;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_frame_start;
  logic        i_pix_valid;
  logic [1:0]  i_pix_pal;
  logic [2:0]  i_pix_index;
  logic        o_out_valid;
  logic [3:0]  o_red, o_green, o_blue;
  logic        o_transparent;
  logic        i_wr_en;
  logic [1:0]  i_wr_pal;
  logic [2:0]  i_wr_index;
  logic [11:0] i_wr_rgb;
  logic        i_flash_trigger;
  logic [1:0]  i_flash_pal;
  logic        o_flash_active;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 0;

  always #5 clk = ~clk;

  sprite_palette_bank dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_frame_start   (i_frame_start),
    .i_pix_valid     (i_pix_valid),
    .i_pix_pal       (i_pix_pal),
    .i_pix_index     (i_pix_index),
    .o_out_valid     (o_out_valid),
    .o_red           (o_red),
    .o_green         (o_green),
    .o_blue          (o_blue),
    .o_transparent   (o_transparent),
    .i_wr_en         (i_wr_en),
    .i_wr_pal        (i_wr_pal),
    .i_wr_index      (i_wr_index),
    .i_wr_rgb        (i_wr_rgb),
    .i_flash_trigger (i_flash_trigger),
    .i_flash_pal     (i_flash_pal),
    .o_flash_active  (o_flash_active)
  );

  localparam logic [11:0] TB_DEF [4][8] = '{
    '{12'hB21, 12'h0E0, 12'hDA9, 12'h000,
      12'h766, 12'h060, 12'hEEE, 12'h421},
    '{12'h000, 12'hF00, 12'h0F0, 12'h00F,
      12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF},
    '{12'h000, 12'h111, 12'h333, 12'h555,
      12'h777, 12'h999, 12'hBBB, 12'hDDD},
    '{12'h000, 12'h820, 12'hA40, 12'hC60,
      12'hE80, 12'hFA0, 12'hFC4, 12'hFE8}
  };

  // Model: flash is "on" during even-numbered pairs of frames since trigger.
  logic [11:0] m_mem [4][8];
  int          m_cnt, m_frames;
  logic [1:0]  m_fpal;
  logic        exp_valid, exp_tr, exp_active;
  logic [11:0] exp_rgb;

  always @(posedge clk) begin
    bit on;
    if (i_reset) begin
      exp_valid = 0;
      exp_rgb   = '0;
      exp_tr    = 0;
      for (int p = 0; p < 4; p++)
        for (int e = 0; e < 8; e++)
          m_mem[p][e] = TB_DEF[p][e];
      m_cnt    = 0;
      m_frames = 0;
      m_fpal   = '0;
    end else begin
      exp_valid = i_pix_valid;
      if (i_pix_valid) begin
        on = (m_cnt > 0) && (((m_frames / 2) % 2) == 0);
        exp_tr = (i_pix_index == 3'd0);
        if (on && i_pix_pal == m_fpal && !exp_tr)
          exp_rgb = 12'hFFF;
        else
          exp_rgb = m_mem[i_pix_pal][i_pix_index];
      end
      if (i_wr_en)
        m_mem[i_wr_pal][i_wr_index] = i_wr_rgb;
      if (i_flash_trigger) begin
        m_cnt    = 8;
        m_frames = 0;
        m_fpal   = i_flash_pal;
      end else if (i_frame_start && m_cnt > 0) begin
        m_cnt--;
        m_frames++;
      end
    end
    exp_active = (m_cnt > 0);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_valid", 32'(o_out_valid), 32'(exp_valid));
      check("cyc_pix",
            32'({o_transparent, o_red, o_green, o_blue}),
            32'({exp_tr, exp_rgb}));
      check("cyc_active", 32'(o_flash_active), 32'(exp_active));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input bit v, input bit t,
                     input logic [11:0] rgb);
    check(name, 32'({o_out_valid, o_transparent, o_red, o_green, o_blue}),
          32'({v, t, rgb}));
  endtask

  task automatic lookup(input logic [1:0] p, input logic [2:0] x);
    i_pix_valid = 1; i_pix_pal = p; i_pix_index = x;
    step();
    i_pix_valid = 0;
  endtask

  task automatic frame();
    i_frame_start = 1;
    step();
    i_frame_start = 0;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) frame();
  endtask

  task automatic trigger(input logic [1:0] p);
    i_flash_trigger = 1; i_flash_pal = p;
    step();
    i_flash_trigger = 0;
  endtask

  initial begin
    i_reset = 1; i_frame_start = 0; i_pix_valid = 0;
    i_pix_pal = 0; i_pix_index = 0; i_wr_en = 0;
    i_wr_pal = 0; i_wr_index = 0; i_wr_rgb = 0;
    i_flash_trigger = 0; i_flash_pal = 0;
    step();
    chk_en = 1;
    step(); step();
    lit("reset_pix", 0, 0, 12'h000);
    check("reset_active", 32'(o_flash_active), 32'd0);
    i_reset = 0;
    step();

    lookup(0, 2);
    lit("p0i2", 1, 0, 12'hDA9);
    step();
    lit("hold", 0, 0, 12'hDA9);
    lookup(0, 0);
    lit("p0i0_transp", 1, 1, 12'hB21);

    i_wr_en = 1; i_wr_pal = 1; i_wr_index = 5; i_wr_rgb = 12'h123;
    lookup(1, 5);
    i_wr_en = 0;
    lit("rbw_old", 1, 0, 12'h0FF);
    lookup(1, 5);
    lit("rbw_new", 1, 0, 12'h123);
    i_wr_en = 1; i_wr_rgb = 12'h456;
    step();
    i_wr_en = 0;
    lit("wr_no_disturb", 0, 0, 12'h123);

    trigger(0);
    check("flash_active_on", 32'(o_flash_active), 32'd1);
    lookup(0, 3);
    lit("flash_on", 1, 0, 12'hFFF);
    lookup(0, 0);
    lit("flash_transp", 1, 1, 12'hB21);
    lookup(1, 3);
    lit("flash_other_pal", 1, 0, 12'h00F);
    frame();
    i_frame_start = 1;
    lookup(0, 2);
    i_frame_start = 0;
    lit("flash_sample_lookup", 1, 0, 12'hFFF);
    lookup(0, 3);
    lit("flash_off_i3", 1, 0, 12'h000);
    lookup(0, 2);
    lit("flash_off_i2", 1, 0, 12'hDA9);
    frames(2);
    lookup(0, 6);
    lit("flash_on_again", 1, 0, 12'hFFF);
    frames(3);
    check("active_after7", 32'(o_flash_active), 32'd1);
    frame();
    check("inactive_after8", 32'(o_flash_active), 32'd0);
    lookup(0, 6);
    lit("post_flash", 1, 0, 12'hEEE);

    i_frame_start = 1;
    trigger(0);
    i_frame_start = 0;
    frames(5);
    check("active_cnt3", 32'(o_flash_active), 32'd1);
    trigger(2);
    lookup(2, 1);
    lit("retrig_newpal", 1, 0, 12'hFFF);
    lookup(0, 1);
    lit("retrig_oldpal", 1, 0, 12'h0E0);
    frames(7);
    check("retrig_active7", 32'(o_flash_active), 32'd1);
    frame();
    check("retrig_done8", 32'(o_flash_active), 32'd0);

    i_wr_en = 1; i_wr_pal = 0; i_wr_index = 1; i_wr_rgb = 12'h5A5;
    step();
    i_wr_en = 0;
    lookup(0, 1);
    lit("p0i1_written", 1, 0, 12'h5A5);
    trigger(0);
    frame();
    i_reset = 1;
    lookup(0, 1);
    i_reset = 0;
    lit("reset_mid", 0, 0, 12'h000);
    check("reset_flash", 32'(o_flash_active), 32'd0);
    lookup(0, 1);
    lit("p0i1_restored", 1, 0, 12'h0E0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
